// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and frame constants for the A2D SPI responder.
// The channel select field sits in command bits [13:11].
package a2d_resp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} resp_state_t;

  localparam int FRAME_LEN = 16;
  localparam int CH_MSB    = 13;
  localparam int CH_LSB    = 11;
  localparam int BIT_CNT_W = 5;
  localparam int BIT_SAT   = 17;

endpackage

// File: rtl/a2d_spi_resp_edge_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, followed by an edge detector.
// RST_VAL is the idle level of the pin, so leaving reset never produces a false edge.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~prev_reg;
  assign fall  = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel A2D converter: returns the channel selected by
// the previous command frame while capturing the current 16-bit command.
module a2d_spi_resp #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [8*DATA_W-1:0] ch_data,
  output logic [15:0]         cmd,
  output logic                cmd_vld,
  output logic                frame_err,
  output logic [2:0]          chan_ptr,
  output logic [15:0]         trans_cnt
);

  import a2d_resp_pkg::*;

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .din(SS_n),
    .level(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(SCLK),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .din(MOSI),
    .level(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [DATA_W-1:0] ch_arr [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
      assign ch_arr[gi] = ch_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  resp_state_t          state_reg, state_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [15:0]          rx_shft_reg, rx_shft_next;
  logic [15:0]          tx_shft_reg, tx_shft_next;
  logic [15:0]          cmd_reg, cmd_next;
  logic [2:0]           chan_ptr_reg, chan_ptr_next;
  logic [15:0]          trans_cnt_reg, trans_cnt_next;
  logic                 cmd_vld_reg, cmd_vld_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 fall_pend_reg, fall_pend_next;
  logic [FLUSH_W-1:0]   flush_cnt_reg;
  logic                 armed_reg;
  logic                 flush_done;

  // A reset taken mid-frame must not let the tail of that frame look like a new one:
  // frames are only accepted once SS_n has been seen high after the chain has flushed.
  assign flush_done = (flush_cnt_reg == FLUSH_W'(SYNC_STAGES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_reg <= '0;
      armed_reg     <= 1'b0;
    end else begin
      if (!flush_done)
        flush_cnt_reg <= flush_cnt_reg + FLUSH_W'(1);
      armed_reg <= armed_reg | (flush_done & ss_sync);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_shft_reg   <= '0;
      tx_shft_reg   <= '0;
      cmd_reg       <= '0;
      chan_ptr_reg  <= '0;
      trans_cnt_reg <= '0;
      cmd_vld_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      fall_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_shft_reg   <= rx_shft_next;
      tx_shft_reg   <= tx_shft_next;
      cmd_reg       <= cmd_next;
      chan_ptr_reg  <= chan_ptr_next;
      trans_cnt_reg <= trans_cnt_next;
      cmd_vld_reg   <= cmd_vld_next;
      frame_err_reg <= frame_err_next;
      fall_pend_reg <= fall_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_shft_next   = rx_shft_reg;
    tx_shft_next   = tx_shft_reg;
    cmd_next       = cmd_reg;
    chan_ptr_next  = chan_ptr_reg;
    trans_cnt_next = trans_cnt_reg;
    cmd_vld_next   = 1'b0;
    frame_err_next = 1'b0;
    fall_pend_next = fall_pend_reg;

    case (state_reg)
      IDLE: begin
        if (armed_reg && (ss_fall || fall_pend_reg)) begin
          tx_shft_next   = 16'(ch_arr[chan_ptr_reg]);
          rx_shft_next   = '0;
          bit_cnt_next   = '0;
          fall_pend_next = 1'b0;
          state_next     = SHIFT;
        end
      end

      SHIFT: begin
        if (ss_rise) begin
          state_next = DONE;
        end else begin
          if (sclk_rise) begin
            rx_shft_next = {rx_shft_reg[14:0], mosi_sync};
            if (bit_cnt_reg != BIT_CNT_W'(BIT_SAT))
              bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
          end
          // The fall before the first rise is the back porch; MSB is already on MISO.
          if (sclk_fall && (bit_cnt_reg != '0))
            tx_shft_next = {tx_shft_reg[14:0], 1'b0};
        end
      end

      DONE: begin
        if (ss_fall)
          fall_pend_next = 1'b1;
        if (bit_cnt_reg == BIT_CNT_W'(FRAME_LEN)) begin
          cmd_next       = rx_shft_reg;
          chan_ptr_next  = rx_shft_reg[CH_MSB:CH_LSB];
          trans_cnt_next = trans_cnt_reg + 16'd1;
          cmd_vld_next   = 1'b1;
        end else begin
          frame_err_next = 1'b1;
        end
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign MISO      = ~ss_sync & tx_shft_reg[15];
  assign cmd       = cmd_reg;
  assign cmd_vld   = cmd_vld_reg;
  assign frame_err = frame_err_reg;
  assign chan_ptr  = chan_ptr_reg;
  assign trans_cnt = trans_cnt_reg;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Randomized bench for a2d_spi_resp: a bench-side SPI master plus a frame-level model
// of the responder (selected channel, command register, good-frame counter).
module tb_a2d_spi_resp;

  localparam int DATA_W = 12;
  localparam int HALF   = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                SS_n = 1'b1;
  logic                SCLK = 1'b1;
  logic                MOSI = 1'b0;
  logic [8*DATA_W-1:0] ch_data = '0;
  logic                MISO;
  logic [15:0]         cmd;
  logic                cmd_vld;
  logic                frame_err;
  logic [2:0]          chan_ptr;
  logic [15:0]         trans_cnt;

  a2d_spi_resp #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_data(ch_data), .cmd(cmd), .cmd_vld(cmd_vld), .frame_err(frame_err),
    .chan_ptr(chan_ptr), .trans_cnt(trans_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  logic [15:0] m_cmd = '0;
  logic [2:0]  m_chan = '0;
  logic [15:0] m_cnt = '0;
  bit          settled = 1'b0;
  int          vld_seen = 0;
  int          err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Outside the post-frame window the registered outputs must match the model and no pulse may appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (settled) begin
        checks++;
        if ({cmd, chan_ptr, trans_cnt, cmd_vld, frame_err} !== {m_cmd, m_chan, m_cnt, 2'b00}) begin
          errors++;
          $display("FAIL steady: got cmd=%h chan=%0d cnt=%h vld=%b err=%b expected cmd=%h chan=%0d cnt=%h vld=0 err=0",
                   cmd, chan_ptr, trans_cnt, cmd_vld, frame_err, m_cmd, m_chan, m_cnt);
        end
      end else begin
        if (cmd_vld === 1'b1) vld_seen++;
        if (frame_err === 1'b1) err_seen++;
      end
    end
  end

  task automatic do_reset_checks();
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_chan", {29'd0, chan_ptr}, 32'd0);
    chk("rst_cnt", {16'd0, trans_cnt}, 32'd0);
    chk("rst_pulses", {30'd0, cmd_vld, frame_err}, 32'd0);
  endtask

  task automatic do_frame(input logic [15:0] mosi_w, input int nbits, input int chg_at,
                          input logic [DATA_W-1:0] chg_val, input int rst_at,
                          output logic [15:0] got);
    logic [15:0] exp_w;
    logic        exp_bit;
    bit          was_reset;
    int          exp_vld;
    int          exp_err;
    was_reset = 1'b0;
    exp_w     = 16'(ch_data[m_chan*DATA_W +: DATA_W]);
    got       = '0;
    vld_seen  = 0;
    err_seen  = 0;
    SS_n      = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at)
        ch_data[m_chan*DATA_W +: DATA_W] = chg_val;
      if (i == rst_at) begin
        settled = 1'b0;
        rst_n   = 1'b0;
        #3;
        do_reset_checks();
        tick(2);
        m_cmd   = '0;
        m_chan  = '0;
        m_cnt   = '0;
        rst_n   = 1'b1;
        settled = 1'b1;
        was_reset = 1'b1;
      end
      SCLK = 1'b0;
      MOSI = (i < 16) ? mosi_w[15-i] : 1'($urandom);
      tick(HALF);
      exp_bit = (was_reset || i >= 16) ? 1'b0 : exp_w[15-i];
      chk("miso_bit", {31'd0, MISO}, {31'd0, exp_bit});
      if (i < 16) got[15-i] = MISO;
      SCLK = 1'b1;
      tick(HALF);
    end
    SS_n    = 1'b1;
    settled = 1'b0;
    tick(10);
    if (was_reset) begin
      exp_vld = 0;
      exp_err = 0;
    end else if (nbits == 16) begin
      m_cmd   = mosi_w;
      m_chan  = mosi_w[13:11];
      m_cnt   = m_cnt + 16'd1;
      exp_vld = 1;
      exp_err = 0;
    end else begin
      exp_vld = 0;
      exp_err = 1;
    end
    chk("cmd_vld_pulses", vld_seen, exp_vld);
    chk("frame_err_pulses", err_seen, exp_err);
    settled = 1'b1;
    tick(4);
    frame_no++;
    $display("frame %0d: mosi=%h bits=%0d rst_at=%0d miso=%h cmd=%h chan=%0d cnt=%h vld=%0d err=%0d",
             frame_no, mosi_w, nbits, rst_at, got, cmd, chan_ptr, trans_cnt, vld_seen, err_seen);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] mw;
    int          nb;
    int          ca;
    int          ra;

    for (int c = 0; c < 8; c++)
      ch_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    ch_data[0 +: DATA_W] = 12'hABC;

    tick(3);
    do_reset_checks();
    rst_n = 1'b1;
    tick(10);
    settled = 1'b1;

    // Command selects ch3, response carries ch0 from the reset pointer.
    do_frame(16'h1800, 16, -1, '0, -1, got);
    chk("f1_miso_word", {16'd0, got}, 32'h0ABC);
    chk("f1_cmd", {16'd0, cmd}, 32'h1800);
    chk("f1_chan", {29'd0, chan_ptr}, 32'd3);
    chk("f1_cnt", {16'd0, trans_cnt}, 32'd1);

    ch_data[3*DATA_W +: DATA_W] = 12'h123;
    do_frame(16'h0000, 16, -1, '0, -1, got);
    chk("f2_miso_word", {16'd0, got}, 32'h0123);
    chk("f2_chan", {29'd0, chan_ptr}, 32'd0);
    chk("f2_cnt", {16'd0, trans_cnt}, 32'd2);

    // Short frame leaves the pointer alone, so the next frame still returns ch0.
    do_frame(16'h3800, 9, -1, '0, -1, got);
    chk("short_chan", {29'd0, chan_ptr}, 32'd0);
    chk("short_cnt", {16'd0, trans_cnt}, 32'd2);
    do_frame(16'h2800, 16, -1, '0, -1, got);
    chk("after_short_word", {16'd0, got}, 32'h0ABC);
    chk("after_short_chan", {29'd0, chan_ptr}, 32'd5);

    do_frame(16'h1234, 17, -1, '0, -1, got);
    chk("long_cmd", {16'd0, cmd}, 32'h2800);

    ch_data[5*DATA_W +: DATA_W] = 12'h555;
    do_frame(16'h0000, 16, 4, 12'hAAA, -1, got);
    chk("midchg_word", {16'd0, got}, 32'h0555);

    settled = 1'b0;
    force dut.trans_cnt_reg = 16'hFFFF;
    tick(1);
    release dut.trans_cnt_reg;
    m_cnt = 16'hFFFF;
    tick(1);
    settled = 1'b1;
    do_frame(16'h0800, 16, -1, '0, -1, got);
    chk("wrap_cnt", {16'd0, trans_cnt}, 32'h0000);

    ch_data[0 +: DATA_W] = 12'h9C3;
    do_frame(16'h3000, 16, -1, '0, 6, got);
    do_frame(16'h0000, 16, -1, '0, -1, got);
    chk("post_rst_word", {16'd0, got}, 32'h09C3);
    chk("post_rst_cnt", {16'd0, trans_cnt}, 32'd1);

    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < 8; c++)
        ch_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      mw = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      do_frame(mw, nb, ca, DATA_W'($urandom), ra, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
